// File: rtl/spart_arb_pkg.sv
// Shared state encoding and SPART register map for the SPART transmit arbiter.
package spart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL    = 3'd1,
    RESP    = 3'd2,
    BACKOFF = 3'd3,
    WRITE   = 3'd4,
    GAP     = 3'd5
  } state_e;

  localparam logic [7:0] SPART_STATUS_ADDR = 8'h10;
  localparam logic [7:0] SPART_DATA_ADDR   = 8'h11;
  localparam int         TX_FULL_BIT       = 24;
  localparam int         DATA_LSB          = 24;

endpackage

// File: rtl/spart_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from rr_ptr+1, wrapping.
module spart_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx_s;

  // Walk from the farthest candidate back to the nearest so the nearest set request wins.
  always_comb begin
    winner    = '0;
    idx_s     = '0;
    any_valid = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_s = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/spart_tx_arb.sv
// Citron-bus master sharing the SPART TX queue between NUM_REQ byte-stream requesters.
// Optional message locking is enabled by defining SPART_TX_ARB_LOCK_EN.
module spart_tx_arb
  import spart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int BACKOFF_CYC = 4,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 citron_addr,
  output logic                       citron_rdy,
  output logic                       citron_wr,
  output logic [31:0]                citron_writedata,
  input  logic [31:0]                citron_readdata,
  input  logic                       citron_stall,
  input  logic                       citron_match,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           tx_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BO_W  = $clog2(BACKOFF_CYC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [BO_W-1:0]    bo_q, bo_d;
  logic               miss_q, miss_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic [7:0]         addr_q, addr_d;
  logic               rdy_q, rdy_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [IDX_W-1:0]   pick_s;
  logic               any_s;
  logic               locked_s;
  logic               unused_rd_s;

  assign unused_rd_s = ^{citron_readdata[31:TX_FULL_BIT+1], citron_readdata[TX_FULL_BIT-1:0]};

  spart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_q),
    .winner    (pick_s),
    .any_valid (any_s)
  );

`ifdef SPART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;

  // A written byte without req_last keeps the grant for the rest of its message.
  always_comb begin
    if (state_q == WRITE && !citron_stall) begin
      lock_d = ~req_last[grant_q];
    end else begin
      lock_d = lock_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign locked_s = lock_q;
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;
  assign locked_s      = 1'b0;
`endif

  // Transaction sequencing; req_ready is combinational so it lands in the accepting WRITE cycle.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    bo_d        = bo_q;
    miss_d      = miss_q;
    tx_count_d  = tx_count_q;
    req_ready_s = '0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          grant_d = pick_s;
          state_d = POLL;
        end else begin
          state_d = IDLE;
        end
      end
      POLL: begin
        if (!citron_stall) begin
          miss_d  = ~citron_match;
          state_d = RESP;
        end else begin
          state_d = POLL;
        end
      end
      RESP: begin
        if (miss_q || citron_readdata[TX_FULL_BIT]) begin
          bo_d    = '0;
          state_d = BACKOFF;
        end else begin
          state_d = WRITE;
        end
      end
      BACKOFF: begin
        if (bo_q == BO_W'(BACKOFF_CYC - 1)) begin
          bo_d    = '0;
          state_d = POLL;
        end else begin
          bo_d    = bo_q + BO_W'(1);
        end
      end
      WRITE: begin
        if (!citron_stall) begin
          req_ready_s = NUM_REQ'(1) << grant_q;
          tx_count_d  = tx_count_q + CNT_W'(1);
          rr_d        = grant_q;
          state_d     = GAP;
        end else begin
          state_d = WRITE;
        end
      end
      GAP: begin
        if (locked_s) begin
          state_d = POLL;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    addr_d  = 8'h00;
    rdy_d   = 1'b0;
    wr_d    = 1'b0;
    wdata_d = 32'h0000_0000;
    busy_d  = (state_d != IDLE);
    case (state_d)
      POLL: begin
        addr_d = SPART_STATUS_ADDR;
        rdy_d  = 1'b1;
      end
      WRITE: begin
        addr_d                  = SPART_DATA_ADDR;
        rdy_d                   = 1'b1;
        wr_d                    = 1'b1;
        wdata_d[DATA_LSB +: 8]  = req_data[{grant_d, 3'b000} +: 8];
      end
      default: begin
        addr_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= IDX_W'(NUM_REQ - 1);
      bo_q       <= '0;
      miss_q     <= 1'b0;
      tx_count_q <= '0;
      addr_q     <= 8'h00;
      rdy_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      bo_q       <= bo_d;
      miss_q     <= miss_d;
      tx_count_q <= tx_count_d;
      addr_q     <= addr_d;
      rdy_q      <= rdy_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready        = req_ready_s;
  assign citron_addr      = addr_q;
  assign citron_rdy       = rdy_q;
  assign citron_wr        = wr_q;
  assign citron_writedata = wdata_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;
  assign tx_count         = tx_count_q;

endmodule

// File: doc/spart_tx_arb.md
Name: spart_tx_arb

Overview:
- Citron-bus master that shares the SPART transmit queue between NUM_REQ byte-stream requesters (e.g. CPU console path, debug/trace unit, boot monitor).
- Per byte, polls SPART status at address 0x10, then writes the byte to data address 0x11 only when the TX queue is not full. Requesters never see a dropped byte.
- Sits between the requesters and a Citron bus slave port wired to the SPART.
- Round-robin arbitration, with optional message locking.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BACKOFF_CYC, 4, idle cycles between status polls while the TX queue reports full (>=1).
- CNT_W, 16, width of the transmitted-byte counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*8  byte for requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  last byte of message (used only with macro)
- req_ready  out  NUM_REQ  one-hot accept pulse
- citron_addr  out  8  bus address
- citron_rdy  out  1  transaction request
- citron_wr  out  1  1=write, 0=read
- citron_writedata  out  32  write data, byte in [31:24]
- citron_readdata  in  32  read data, valid the cycle after the read request
- citron_stall  in  1  slave stall; hold the request
- citron_match  in  1  slave address match
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  state != IDLE
- tx_count  out  CNT_W  bytes written to SPART, wraps

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE; all outputs 0 (req_ready, citron_rdy, citron_wr, citron_addr, citron_writedata, busy, tx_count);
  - rr pointer=NUM_REQ-1, so requester 0 wins first; grant_id=0; backoff counter=0.
  - Reset mid-transaction abandons the byte; req_ready is never pulsed for it.
- States and transitions:
  - IDLE: if any req_valid, the winner is the first valid requester scanning upward from rr_ptr+1 (wrap at NUM_REQ). Latch grant_id, go to POLL.
  - POLL: drive addr=0x10, rdy=1, wr=0. Stay while citron_stall=1, else go to RESP.
  - RESP: rdy=0. If citron_readdata[24]=1 (TX full) or citron_match was 0 during POLL, go to BACKOFF; else go to WRITE.
  - BACKOFF: count BACKOFF_CYC cycles, then go to POLL. Same grant is kept; no re-arbitration.
  - WRITE: drive addr=0x11, rdy=1, wr=1, writedata={req_data[grant],24'h0}.
    - While citron_stall=1: hold all outputs, req_ready=0.
    - On the first non-stalled cycle: req_ready[grant]=1 for that cycle only, tx_count+1 (mod 2^CNT_W), rr_ptr=grant, go to GAP.
  - GAP: one dead cycle so the SPART queue pointer settles before the next status read. Go to IDLE, or to POLL when locked (see Optional Feature).
- Timing:
  - Minimum 5 cycles per byte: POLL, RESP, WRITE, GAP, plus IDLE or POLL.
  - First poll occurs the cycle after valid is seen in IDLE.
- Requester rules:
  - req_valid/req_data/req_last must be held stable until req_ready.
  - Dropping valid after grant is a protocol violation; behaviour is undefined.
- Outside POLL and WRITE: citron_rdy=0, citron_wr=0, citron_addr=0, writedata=0.
- Simultaneous events:
  - New valid arriving during a transaction waits for IDLE.
  - Only one req_ready bit is ever high.
- tx_count wraps from all-ones to 0 silently.

Optional Feature:
- Macro SPART_TX_ARB_LOCK_EN.
- When defined:
  - After a WRITE whose req_last[grant]=0, GAP goes to POLL with the same grant (no arbitration).
  - The lock releases after a byte with req_last=1; the next arbitration then runs from IDLE.
  - Messages are never interleaved.
- When undefined: req_last is ignored, and arbitration happens per byte (GAP always goes to IDLE).

Decomposition:
- Package spart_arb_pkg holds:
  - state enum {IDLE, POLL, RESP, BACKOFF, WRITE, GAP};
  - SPART_STATUS_ADDR=8'h10, SPART_DATA_ADDR=8'h11;
  - TX_FULL_BIT=24, DATA_LSB=24.
- Sub-module spart_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_valid.

Test Plan:
- Single requester: req0 valid 0x41, readdata=0 → POLL addr 0x10 wr=0; WRITE addr 0x11 writedata 0x41000000; req_ready[0] pulses 1 cycle; tx_count=1.
- Fairness: req0..2 continuously valid, status never full → grant order 0,1,2,0,1,2; each req_ready is one-hot with at least 5 cycles between pulses.
- Backpressure: readdata[24]=1 for 2 polls, then 0, BACKOFF_CYC=4 → polls spaced 4 idle cycles apart; exactly one write after the third poll; grant unchanged.
- Stall: citron_stall=1 for 3 cycles in WRITE → bus outputs held constant; single req_ready on the 4th cycle; tx_count+1 only.
- Lock, with macro: req0 sends 3 bytes (last on the 3rd), req1 valid throughout → order 0,0,0,1. Without macro → 0,1,0,1,0.
- Reset during BACKOFF → outputs 0 the same cycle. After release, with req0 and req2 both valid → req0 is granted first; tx_count=0.
